lb_reg_bank: RTL and testbench

Parametrised bank of load registers on the PicoBlaze I/O port bus. It generalises the single 8-bit load register to DEPTH registers of WIDTH bits, all addressed through one port. It adds registered read-back, per-register sticky change flags with an interrupt, and optional double-buffered (shadow) commit. It sits between the processor's port_id/out_port/in_port strobes and the peripheral fabric, which consumes the parallel register outputs.

---
 rtl/lb_reg_bank_if.sv | 27 ++
 rtl/lb_reg_bank.sv | 118 +++++++++++
 tb/tb_lb_reg_bank.sv | 246 ++++++++++++++++++++++++
 3 files changed

// File: rtl/lb_reg_bank_if.sv
// lb_reg_bank_if: PicoBlaze-style port bus used by lb_reg_bank.
//   master : the processor side. It drives addr, d_in, write_strobe,
//            read_strobe and commit, and it receives d_out and rd_valid.
//   slave  : the register bank. The directions are the reverse of master.
// Parameters: WIDTH (data width), ADDR_W (address width).
interface lb_reg_bank_if #(
  parameter int WIDTH  = 8,
  parameter int ADDR_W = 2
);
  logic [ADDR_W-1:0] addr;
  logic [WIDTH-1:0]  d_in;
  logic              write_strobe;
  logic              read_strobe;
  logic              commit;
  logic [WIDTH-1:0]  d_out;
  logic              rd_valid;

  modport master (
    output addr, d_in, write_strobe, read_strobe, commit,
    input  d_out, rd_valid
  );

  modport slave (
    input  addr, d_in, write_strobe, read_strobe, commit,
    output d_out, rd_valid
  );
endinterface

// File: rtl/lb_reg_bank.sv
// lb_reg_bank: a bank of DEPTH load registers of WIDTH bits. All registers
// are addressed through a single PicoBlaze I/O port. The bank provides:
//   - registered read-back. d_out and rd_valid appear one clock after
//     read_strobe.
//   - a sticky change flag for each register. A valid read clears the flag.
//     If a set and a clear hit the same flag in one cycle, the set wins.
//   - an irq output, which is the OR of all the change flags.
// Optional feature: when the macro LB_REG_BANK_SHADOW_EN is defined, each
// register gets a shadow. Writes and reads use the shadow. A commit pulse
// copies every shadow into the active registers.
// Ports:
//   clk       rising-edge clock
//   reset     synchronous active-high reset
//   bus       lb_reg_bank_if.slave (addr, d_in, strobes, commit, d_out, rd_valid)
//   regs_flat active register values, register i at [i*WIDTH +: WIDTH]
//   changed   sticky per-register change flags
//   irq       OR of changed
module lb_reg_bank #(
  parameter int               WIDTH     = 8,
  parameter int               DEPTH     = 4,
  parameter int               ADDR_W    = 2,
  parameter logic [WIDTH-1:0] RESET_VAL = {WIDTH{1'b0}}
) (
  input  logic                   clk,
  input  logic                   reset,
  lb_reg_bank_if.slave           bus,
  output logic [DEPTH*WIDTH-1:0] regs_flat,
  output logic [DEPTH-1:0]       changed,
  output logic                   irq
);

  logic [WIDTH-1:0] act_r     [DEPTH];
  logic [WIDTH-1:0] act_nxt_s [DEPTH];
  logic [DEPTH-1:0] changed_r;
  logic [DEPTH-1:0] changed_nxt_s;
  logic [WIDTH-1:0] d_out_r;
  logic             rd_valid_r;
  logic [WIDTH-1:0] rd_data_s;
  logic             wr_hit_s;
  logic             rd_hit_s;

`ifdef LB_REG_BANK_SHADOW_EN
  logic [WIDTH-1:0] shd_r     [DEPTH];
  logic [WIDTH-1:0] shd_nxt_s [DEPTH];
`else
  logic             commit_unused_s;
  assign commit_unused_s = bus.commit;
`endif

  // The address is widened by one bit so that DEPTH == 2**ADDR_W compares correctly.
  assign wr_hit_s = bus.write_strobe && ({1'b0, bus.addr} < (ADDR_W+1)'(DEPTH));
  assign rd_hit_s = bus.read_strobe  && ({1'b0, bus.addr} < (ADDR_W+1)'(DEPTH));

  // Compute the next register contents, the change flags and the read data.
  always_comb begin
    rd_data_s     = {WIDTH{1'b0}};
    changed_nxt_s = {DEPTH{1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      act_nxt_s[i] = act_r[i];
`ifdef LB_REG_BANK_SHADOW_EN
      shd_nxt_s[i] = (wr_hit_s && bus.addr == ADDR_W'(i)) ? bus.d_in : shd_r[i];
      // A commit picks up a write from the same cycle.
      act_nxt_s[i] = bus.commit ? shd_nxt_s[i] : act_r[i];
      // The read returns the value from before any write in this cycle.
      rd_data_s    = (rd_hit_s && bus.addr == ADDR_W'(i)) ? shd_r[i] : rd_data_s;
`else
      act_nxt_s[i] = (wr_hit_s && bus.addr == ADDR_W'(i)) ? bus.d_in : act_r[i];
      rd_data_s    = (rd_hit_s && bus.addr == ADDR_W'(i)) ? act_r[i] : rd_data_s;
`endif
      // Set on any change of the active value. A set overrides the clear-on-read.
      changed_nxt_s[i] = (act_nxt_s[i] != act_r[i]) ||
                         (changed_r[i] && !(rd_hit_s && bus.addr == ADDR_W'(i)));
    end
  end

  // Register the state. Reset takes priority over every strobe.
  always_ff @(posedge clk) begin
    if (reset) begin
      for (int i = 0; i < DEPTH; i++) begin
        act_r[i] <= RESET_VAL;
`ifdef LB_REG_BANK_SHADOW_EN
        shd_r[i] <= RESET_VAL;
`endif
      end
      changed_r  <= {DEPTH{1'b0}};
      d_out_r    <= {WIDTH{1'b0}};
      rd_valid_r <= 1'b0;
    end else begin
      for (int i = 0; i < DEPTH; i++) begin
        act_r[i] <= act_nxt_s[i];
`ifdef LB_REG_BANK_SHADOW_EN
        shd_r[i] <= shd_nxt_s[i];
`endif
      end
      changed_r  <= changed_nxt_s;
      rd_valid_r <= bus.read_strobe;
      if (bus.read_strobe) begin
        d_out_r <= rd_data_s;
      end else begin
        d_out_r <= d_out_r;
      end
    end
  end

  // Flatten the active registers onto the parallel output.
  always_comb begin
    regs_flat = {(DEPTH*WIDTH){1'b0}};
    for (int i = 0; i < DEPTH; i++) begin
      regs_flat[i*WIDTH +: WIDTH] = act_r[i];
    end
  end

  assign changed      = changed_r;
  assign irq          = |changed_r;
  assign bus.d_out    = d_out_r;
  assign bus.rd_valid = rd_valid_r;

endmodule

// File: tb/tb_lb_reg_bank.sv
// tb_lb_reg_bank: self-checking bench for lb_reg_bank. It uses two
// instances that share one clock and one reset:
//   unit 0: DEPTH=4
//   unit 1: DEPTH=3, which makes address 3 out of range
// Both instances use RESET_VAL=8'hA5. Expected read data is queued when a
// read strobe is driven and popped when rd_valid appears.
module tb_lb_reg_bank;

`ifdef LB_REG_BANK_SHADOW_EN
  localparam bit SHADOW = 1'b1;
`else
  localparam bit SHADOW = 1'b0;
`endif

  logic        clk;
  logic        reset;
  logic [31:0] flat4;
  logic [23:0] flat3;
  logic [3:0]  chg4;
  logic [2:0]  chg3;
  logic        irq4, irq3;

  lb_reg_bank_if #(.WIDTH(8), .ADDR_W(2)) bus4 ();
  lb_reg_bank_if #(.WIDTH(8), .ADDR_W(2)) bus3 ();

  lb_reg_bank #(.WIDTH(8), .DEPTH(4), .ADDR_W(2), .RESET_VAL(8'hA5)) dut4 (
    .clk(clk), .reset(reset), .bus(bus4.slave),
    .regs_flat(flat4), .changed(chg4), .irq(irq4)
  );

  lb_reg_bank #(.WIDTH(8), .DEPTH(3), .ADDR_W(2), .RESET_VAL(8'hA5)) dut3 (
    .clk(clk), .reset(reset), .bus(bus3.slave),
    .regs_flat(flat3), .changed(chg3), .irq(irq3)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Collect the outputs of both units into per-unit views.
  logic [7:0]  obs_dout [2];
  logic        obs_rdv  [2];
  logic [31:0] obs_flat [2];
  logic [3:0]  obs_chg  [2];
  logic        obs_irq  [2];
  assign obs_dout[0] = bus4.d_out;
  assign obs_dout[1] = bus3.d_out;
  assign obs_rdv[0]  = bus4.rd_valid;
  assign obs_rdv[1]  = bus3.rd_valid;
  assign obs_flat[0] = flat4;
  assign obs_flat[1] = {8'h00, flat3};
  assign obs_chg[0]  = chg4;
  assign obs_chg[1]  = {1'b0, chg3};
  assign obs_irq[0]  = irq4;
  assign obs_irq[1]  = irq3;

  int n_checks = 0;
  int n_errors = 0;

  // Reference model state.
  logic [7:0] m_act  [2][4];
  logic [7:0] m_shd  [2][4];
  logic [3:0] m_chg  [2];
  logic [7:0] m_last [2];
  logic       exp_rdv[2];
  int         m_depth[2] = '{4, 3};
  logic [7:0] sb_q0[$];
  logic [7:0] sb_q1[$];

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %h expected %h at %0t", tag, act, exp, $time);
    end
  endtask

  task automatic model_reset();
    for (int u = 0; u < 2; u++) begin
      for (int i = 0; i < 4; i++) begin
        m_act[u][i] = 8'hA5;
        m_shd[u][i] = 8'hA5;
      end
      m_chg[u]   = 4'b0000;
      m_last[u]  = 8'h00;
      exp_rdv[u] = 1'b0;
    end
    sb_q0.delete();
    sb_q1.delete();
  endtask

  task automatic model_step(input int u, input logic [1:0] a, input logic [7:0] d,
                            input logic we, input logic re, input logic cm);
    logic [7:0] na [4];
    logic [7:0] ns [4];
    logic [7:0] rexp;
    logic [3:0] setf, clrf;
    bit wr_ok, rd_ok;
    wr_ok = we && (int'(a) < m_depth[u]);
    rd_ok = re && (int'(a) < m_depth[u]);
    rexp  = rd_ok ? (SHADOW ? m_shd[u][a] : m_act[u][a]) : 8'h00;
    exp_rdv[u] = re;
    if (re) begin
      if (u == 0) sb_q0.push_back(rexp);
      else        sb_q1.push_back(rexp);
    end
    for (int i = 0; i < 4; i++) begin
      na[i] = m_act[u][i];
      ns[i] = m_shd[u][i];
    end
    if (wr_ok) begin
      if (SHADOW) ns[a] = d;
      else        na[a] = d;
    end
    if (SHADOW && cm) begin
      for (int i = 0; i < 4; i++) na[i] = ns[i];
    end
    for (int i = 0; i < 4; i++) begin
      setf[i] = (i < m_depth[u]) && (na[i] != m_act[u][i]);
      clrf[i] = rd_ok && (int'(a) == i);
      m_act[u][i] = na[i];
      m_shd[u][i] = ns[i];
    end
    m_chg[u] = setf | (m_chg[u] & ~clrf);
  endtask

  function automatic logic [31:0] model_flat(input int u);
    logic [31:0] f;
    f = 32'h0;
    for (int i = 0; i < m_depth[u]; i++) f[i*8 +: 8] = m_act[u][i];
    return f;
  endfunction

  task automatic compare_all();
    logic [7:0] e;
    for (int u = 0; u < 2; u++) begin
      check("rd_valid", {31'b0, obs_rdv[u]}, {31'b0, exp_rdv[u]});
      if (obs_rdv[u]) begin
        if ((u == 0 && sb_q0.size() == 0) || (u == 1 && sb_q1.size() == 0)) begin
          check("sb_empty", 32'd1, 32'd0);
        end else begin
          e = (u == 0) ? sb_q0.pop_front() : sb_q1.pop_front();
          m_last[u] = e;
        end
      end
      check("d_out", {24'b0, obs_dout[u]}, {24'b0, m_last[u]});
      check("regs_flat", obs_flat[u], model_flat(u));
      check("changed", {28'b0, obs_chg[u]}, {28'b0, m_chg[u]});
      check("irq", {31'b0, obs_irq[u]}, {31'b0, |m_chg[u]});
    end
  endtask

  // Drive one cycle on unit u (the other unit idles), advance the model, then check.
  task automatic cycle(input int u, input logic rst, input logic [1:0] a, input logic [7:0] d,
                       input logic we, input logic re, input logic cm);
    reset             = rst;
    bus4.addr         = (u == 0) ? a : 2'd0;
    bus4.d_in         = (u == 0) ? d : 8'h00;
    bus4.write_strobe = (u == 0) && we;
    bus4.read_strobe  = (u == 0) && re;
    bus4.commit       = (u == 0) && cm;
    bus3.addr         = (u == 1) ? a : 2'd0;
    bus3.d_in         = (u == 1) ? d : 8'h00;
    bus3.write_strobe = (u == 1) && we;
    bus3.read_strobe  = (u == 1) && re;
    bus3.commit       = (u == 1) && cm;
    exp_rdv[0] = 1'b0;
    exp_rdv[1] = 1'b0;
    if (rst) model_reset();
    else     model_step(u, a, d, we, re, cm);
    @(posedge clk);
    #1;
    compare_all();
  endtask

  initial begin
    model_reset();
    cycle(0, 1'b1, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("rst_flat", obs_flat[0], 32'hA5A5A5A5);
    check("rst_chg", {28'b0, obs_chg[0]}, 32'h0);
    check("rst_irq", {31'b0, obs_irq[0]}, 32'h0);
    check("rst_dout", {24'b0, obs_dout[0]}, 32'h0);

    // Write to address 2, then read it back.
    cycle(0, 1'b0, 2'd2, 8'h3C, 1'b1, 1'b0, 1'b0);
`ifndef LB_REG_BANK_SHADOW_EN
    check("wr_lat", {24'b0, obs_flat[0][23:16]}, 32'h3C);
    check("chg_set", {31'b0, obs_chg[0][2]}, 32'h1);
`endif
    cycle(0, 1'b0, 2'd2, 8'h00, 1'b0, 1'b1, 1'b0);
    check("rd_data", {24'b0, obs_dout[0]}, 32'h3C);
    check("chg_clr", {28'b0, obs_chg[0]}, 32'h0);
    check("irq_fall", {31'b0, obs_irq[0]}, 32'h0);

    // A write of an identical value must not set a flag.
    cycle(0, 1'b0, 2'd1, 8'hA5, 1'b1, 1'b0, 1'b0);
    check("eq_wr", {28'b0, obs_chg[0]}, 32'h0);

    // Out-of-range write and read on the DEPTH=3 unit.
    cycle(1, 1'b0, 2'd3, 8'h77, 1'b1, 1'b0, 1'b0);
    check("oor_wr", obs_flat[1], 32'h00A5A5A5);
    cycle(1, 1'b0, 2'd3, 8'h00, 1'b0, 1'b1, 1'b0);
    check("oor_rd", {24'b0, obs_dout[1]}, 32'h0);

    // Read and write the same address in one cycle.
    cycle(0, 1'b0, 2'd0, 8'h22, 1'b1, 1'b0, 1'b0);
    cycle(0, 1'b0, 2'd0, 8'h11, 1'b1, 1'b1, 1'b0);
    check("rbw_dout", {24'b0, obs_dout[0]}, 32'h22);
`ifndef LB_REG_BANK_SHADOW_EN
    check("rbw_flat", {24'b0, obs_flat[0][7:0]}, 32'h11);
    check("rbw_setwin", {31'b0, obs_chg[0][0]}, 32'h1);
`endif

    // Shadow write, then commit, then write and commit in one cycle.
    // In the direct build the commit input has no effect.
    cycle(0, 1'b0, 2'd0, 8'h55, 1'b1, 1'b0, 1'b0);
`ifdef LB_REG_BANK_SHADOW_EN
    check("shd_hold", {24'b0, obs_flat[0][7:0]}, 32'hA5);
`endif
    cycle(0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b1, 1'b0);
    check("shd_rd", {24'b0, obs_dout[0]}, 32'h55);
    cycle(0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b1);
`ifdef LB_REG_BANK_SHADOW_EN
    check("commit_flat", {24'b0, obs_flat[0][7:0]}, 32'h55);
    check("commit_chg", {31'b0, obs_chg[0][0]}, 32'h1);
`endif
    cycle(0, 1'b0, 2'd1, 8'h66, 1'b1, 1'b0, 1'b1);
    check("wr_commit", {24'b0, obs_flat[0][15:8]}, 32'h66);

    // Reset together with both strobes: the write is lost and no rd_valid appears.
    cycle(0, 1'b1, 2'd3, 8'h99, 1'b1, 1'b1, 1'b0);
    cycle(0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);
    check("rst_mid_rdv", {31'b0, obs_rdv[0]}, 32'h0);
    check("rst_mid_flat", obs_flat[0], 32'hA5A5A5A5);

    // Random traffic on both units.
    for (int k = 0; k < 300; k++) begin
      cycle($urandom_range(0, 1), 1'b0, 2'($urandom_range(0, 3)), 8'($urandom),
            1'($urandom), 1'($urandom), 1'($urandom_range(0, 3) == 0));
    end
    cycle(0, 1'b0, 2'd0, 8'h00, 1'b0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", n_errors, n_checks);
    $finish;
  end

endmodule
